// File: rtl/ysyx_22050710_ifu.sv
// Instruction fetch unit: owns the architectural PC, issues one fetch at a
// time to instruction memory, holds the returned word for decode, and
// restarts fetch at the branch unit's target on a redirect.
module ysyx_22050710_ifu #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_imem_req_valid,
  output logic [ADDR_W-1:0] o_imem_req_addr,
  input  logic              i_imem_req_ready,
  input  logic              i_imem_rsp_valid,
  input  logic [31:0]       i_imem_rsp_data,
  output logic              o_inst_valid,
  output logic [31:0]       o_inst,
  output logic [ADDR_W-1:0] o_inst_pc,
  input  logic              i_inst_ready,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] PC_STEP    = {{(ADDR_W-3){1'b0}}, 3'b100};
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_e            state_r;
  state_e            state_nxt_s;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_nxt_s;
  logic              kill_r;
  logic              kill_nxt_s;
  logic              load_inst_s;
  logic              req_valid_r;
  logic              inst_valid_r;
  logic [31:0]       inst_r;
  logic [ADDR_W-1:0] inst_pc_r;
  logic [ADDR_W-1:0] redirect_pc_s;

  // Redirect targets are always word aligned; low two bits are cleared.
  assign redirect_pc_s = i_redirect_pc & ALIGN_MASK;

  // Next-state, next-PC and kill-flag selection; redirect outranks normal flow.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    kill_nxt_s  = kill_r;
    load_inst_s = 1'b0;
    if (i_redirect) begin
      pc_nxt_s = redirect_pc_s;
      case (state_r)
        ST_REQ: begin
          // An accepted request cannot be recalled, so its response is marked for drop.
          if (i_imem_req_ready) begin
            state_nxt_s = ST_WAIT;
            kill_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (i_imem_rsp_valid) begin
            state_nxt_s = ST_REQ;
            kill_nxt_s  = 1'b0;
          end else begin
            state_nxt_s = ST_WAIT;
            kill_nxt_s  = 1'b1;
          end
        end
        ST_HOLD: begin
          state_nxt_s = ST_REQ;
        end
        default: begin
          state_nxt_s = ST_REQ;
          kill_nxt_s  = 1'b0;
        end
      endcase
    end else begin
      case (state_r)
        ST_REQ: begin
          if (i_imem_req_ready) begin
            state_nxt_s = ST_WAIT;
          end else begin
            state_nxt_s = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (i_imem_rsp_valid) begin
            state_nxt_s = kill_r ? ST_REQ : ST_HOLD;
            kill_nxt_s  = 1'b0;
            load_inst_s = ~kill_r;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (i_inst_ready) begin
            state_nxt_s = ST_REQ;
            pc_nxt_s    = pc_r + PC_STEP;
          end else begin
            state_nxt_s = ST_HOLD;
          end
        end
        default: begin
          state_nxt_s = ST_REQ;
          kill_nxt_s  = 1'b0;
        end
      endcase
    end
  end

  // State, PC, kill flag and registered handshake outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r      <= ST_REQ;
      pc_r         <= RESET_PC;
      kill_r       <= 1'b0;
      req_valid_r  <= 1'b1;
      inst_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      kill_r       <= kill_nxt_s;
      req_valid_r  <= (state_nxt_s == ST_REQ);
      inst_valid_r <= (state_nxt_s == ST_HOLD);
    end
  end

  // Captured instruction word and its PC, stable while held for decode.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      inst_r    <= 32'h0000_0000;
      inst_pc_r <= '0;
    end else if (load_inst_s) begin
      inst_r    <= i_imem_rsp_data;
      inst_pc_r <= pc_r;
    end else begin
      inst_r    <= inst_r;
      inst_pc_r <= inst_pc_r;
    end
  end

  assign o_imem_req_valid = req_valid_r;
  assign o_imem_req_addr  = pc_r;
  assign o_inst_valid     = inst_valid_r;
  assign o_inst           = inst_r;
  assign o_inst_pc        = inst_pc_r;

endmodule

// File: tb/tb_ysyx_22050710_ifu.sv
// Self-checking bench for the instruction fetch unit: directed scenarios with
// literal expectations, then a randomized run against a transaction-level model.
module tb_ysyx_22050710_ifu;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        o_imem_req_valid;
  logic [63:0] o_imem_req_addr;
  logic        i_imem_req_ready = 1'b0;
  logic        i_imem_rsp_valid = 1'b0;
  logic [31:0] i_imem_rsp_data  = 32'h0;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [63:0] o_inst_pc;
  logic        i_inst_ready = 1'b0;
  logic        i_redirect   = 1'b0;
  logic [63:0] i_redirect_pc = 64'h0;

  int checks   = 0;
  int failures = 0;

  // Model: fetch PC, one outstanding-request flag, a drop-next-response flag,
  // and the instruction held for decode.
  logic [63:0] m_pc;
  bit          m_busy;
  bit          m_drop;
  bit          m_held;
  logic [31:0] m_inst;
  logic [63:0] m_inst_pc;

  ysyx_22050710_ifu dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .o_imem_req_valid (o_imem_req_valid),
    .o_imem_req_addr  (o_imem_req_addr),
    .i_imem_req_ready (i_imem_req_ready),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .o_inst_valid     (o_inst_valid),
    .o_inst           (o_inst),
    .o_inst_pc        (o_inst_pc),
    .i_inst_ready     (i_inst_ready),
    .i_redirect       (i_redirect),
    .i_redirect_pc    (i_redirect_pc)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented to the DUT.
  task automatic model_update();
    bit fire;
    bit take;
    bit [63:0] mask;
    mask = 64'hFFFF_FFFF_FFFF_FFFC;
    if (i_rst) begin
      m_pc = 64'h0000_0000_8000_0000;
      m_busy = 1'b0; m_drop = 1'b0; m_held = 1'b0;
      m_inst = 32'h0; m_inst_pc = 64'h0;
    end else begin
      fire = !m_held && !m_busy && i_imem_req_ready;
      take = m_busy && i_imem_rsp_valid;
      if (i_redirect) begin
        m_pc = i_redirect_pc & mask;
        if (fire) begin
          m_busy = 1'b1; m_drop = 1'b1;
        end else if (take) begin
          m_busy = 1'b0; m_drop = 1'b0;
        end else if (m_busy) begin
          m_drop = 1'b1;
        end
        m_held = 1'b0;
      end else begin
        if (fire) begin
          m_busy = 1'b1;
        end else if (take) begin
          m_busy = 1'b0;
          if (m_drop) begin
            m_drop = 1'b0;
          end else begin
            m_held = 1'b1; m_inst = i_imem_rsp_data; m_inst_pc = m_pc;
          end
        end else if (m_held && i_inst_ready) begin
          m_held = 1'b0;
          m_pc = m_pc + 64'd4;
        end
      end
    end
  endtask

  // Compare every DUT output against the model.
  task automatic compare();
    bit exp_req;
    exp_req = !m_held && !m_busy;
    chk("req_valid", {63'h0, o_imem_req_valid}, {63'h0, exp_req});
    if (exp_req) chk("req_addr", o_imem_req_addr, m_pc);
    chk("inst_valid", {63'h0, o_inst_valid}, {63'h0, m_held});
    chk("inst", {32'h0, o_inst}, {32'h0, m_inst});
    chk("inst_pc", o_inst_pc, m_inst_pc);
  endtask

  // Drive one cycle of inputs, clock it, then check outputs on the falling edge.
  task automatic step(input bit rst, input bit rdy, input bit rspv, input logic [31:0] data,
                      input bit iready, input bit redir, input logic [63:0] rpc);
    i_rst = rst; i_imem_req_ready = rdy; i_imem_rsp_valid = rspv; i_imem_rsp_data = data;
    i_inst_ready = iready; i_redirect = redir; i_redirect_pc = rpc;
    @(posedge i_clk);
    model_update();
    @(negedge i_clk);
    compare();
  endtask

  initial begin
    logic [31:0] held_inst;
    @(negedge i_clk);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    chk("rst_req_valid", {63'h0, o_imem_req_valid}, 64'h1);
    chk("rst_inst_valid", {63'h0, o_inst_valid}, 64'h0);
    chk("rst_inst", {32'h0, o_inst}, 64'h0);
    chk("rst_inst_pc", o_inst_pc, 64'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    chk("first_addr", o_imem_req_addr, 64'h0000_0000_8000_0000);

    // Three sequential fetches with a one-cycle memory and ready decode.
    for (int k = 0; k < 3; k++) begin
      chk("seq_req_addr", o_imem_req_addr, 64'h0000_0000_8000_0000 + 64'(4 * k));
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
      step(1'b0, 1'b0, 1'b1, 32'h1111_0000 + 32'(k), 1'b0, 1'b0, 64'h0);
      chk("seq_inst_pc", o_inst_pc, 64'h0000_0000_8000_0000 + 64'(4 * k));
      chk("seq_inst", {32'h0, o_inst}, {32'h0, 32'h1111_0000 + 32'(k)});
      if (k < 2) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
    end

    // Decode stalls for five cycles: held outputs stable, no new request.
    held_inst = o_inst;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 64'h0);
      chk("stall_inst", {32'h0, o_inst}, {32'h0, held_inst});
      chk("stall_no_req", {63'h0, o_imem_req_valid}, 64'h0);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
    chk("after_stall_addr", o_imem_req_addr, 64'h0000_0000_8000_000C);

    // Redirect while waiting; the in-flight word must be dropped.
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 64'h0000_0000_8000_1002);
    step(1'b0, 1'b0, 1'b1, 32'hBAD0_0001, 1'b0, 1'b0, 64'h0);
    chk("wait_redir_no_inst", {63'h0, o_inst_valid}, 64'h0);
    chk("wait_redir_addr", o_imem_req_addr, 64'h0000_0000_8000_1000);

    // Redirect on the same edge as the request handshake.
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 64'h0000_0000_8000_2000);
    step(1'b0, 1'b0, 1'b1, 32'hBAD0_0002, 1'b0, 1'b0, 64'h0);
    chk("hs_redir_no_inst", {63'h0, o_inst_valid}, 64'h0);
    chk("hs_redir_addr", o_imem_req_addr, 64'h0000_0000_8000_2000);

    // Redirect while holding, even with decode ready: no pc+4.
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b1, 32'h2222_2222, 1'b0, 1'b0, 64'h0);
    chk("hold_inst_pc", o_inst_pc, 64'h0000_0000_8000_2000);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 64'h0000_0000_8000_3000);
    chk("hold_redir_addr", o_imem_req_addr, 64'h0000_0000_8000_3000);
    chk("hold_redir_valid", {63'h0, o_inst_valid}, 64'h0);

    // Reset during WAIT, then a late response that must be ignored.
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b1, 32'hBAD0_0003, 1'b0, 1'b0, 64'h0);
    chk("late_rsp_valid", {63'h0, o_inst_valid}, 64'h0);
    chk("late_rsp_addr", o_imem_req_addr, 64'h0000_0000_8000_0000);

    // PC wraps from the top of the address space to zero.
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wrap_top_addr", o_imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b1, 32'h3333_3333, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
    chk("wrap_addr", o_imem_req_addr, 64'h0);

    // Randomized traffic, including spurious responses and rare resets.
    for (int n = 0; n < 4000; n++) begin
      bit r_rst, r_rdy, r_rsp, r_ir, r_red;
      logic [63:0] r_pc;
      r_rst = ($urandom_range(0, 199) == 0);
      r_rdy = ($urandom_range(0, 2) != 0);
      r_rsp = m_busy ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      r_ir  = ($urandom_range(0, 1) == 1);
      r_red = ($urandom_range(0, 9) == 0);
      r_pc  = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) r_pc = 64'hFFFF_FFFF_FFFF_FFF8 | 64'($urandom_range(0, 7));
      step(r_rst, r_rdy, r_rsp, $urandom(), r_ir, r_red, r_pc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
